// File: rtl/blitter_pkg.sv
// Shared definitions for the pixel blitter: FSM state encoding, AHB transfer
// codes, the command sync word, flag bit positions in the flags word, and a
// saturating counter helper.
package blitter_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SIZE  = 3'd1,
    S_BASE  = 3'd2,
    S_FLAGS = 3'd3,
    S_ADDR  = 3'd4,
    S_DATA  = 3'd5,
    S_EMIT  = 3'd6
  } state_e;

  localparam logic [1:0]  HTRANS_IDLE   = 2'b00;
  localparam logic [1:0]  HTRANS_NONSEQ = 2'b10;

  localparam logic [31:0] SYNC_WORD = 32'hFFFF_FFFF;

  // Bit positions inside the flags word (fourth command word)
  localparam int FLAG_TRANS_BIT  = 0;
  localparam int FLAG_MIRROR_BIT = 1;
  localparam int FLAG_KEY_LSB    = 8;

  // 8-bit increment that sticks at 255
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/blit_addr_gen.sv
// Combinational source address generator.
// Maps a (row, col) pixel position to the AHB word address holding it and
// the pixel lane inside that word. With mirror set the column is reflected
// (width-1-col) so each row is read right to left.
//   row_i, col_i   : pixel position being requested
//   width_i        : frame width in pixels
//   base_i         : word-aligned source base byte address
//   mirror_i       : horizontal mirror enable
//   addr_o         : word-aligned byte address (32-bit, wraps modulo 2^32)
//   lane_o         : pixel lane within the word, lane 0 = bits [PIX_W-1:0]
module blit_addr_gen
  import blitter_pkg::*;
#(
  parameter  int PIX_W  = 16,
  parameter  int DIM_W  = 16,
  localparam int PPW    = 32 / PIX_W,
  localparam int LANE_W = (PPW > 1) ? $clog2(PPW) : 1
) (
  input  logic [DIM_W-1:0]  row_i,
  input  logic [DIM_W-1:0]  col_i,
  input  logic [DIM_W-1:0]  width_i,
  input  logic [31:0]       base_i,
  input  logic              mirror_i,
  output logic [31:0]       addr_o,
  output logic [LANE_W-1:0] lane_o
);

  localparam int SH = $clog2(PPW);

  logic [DIM_W-1:0]   c_s;
  logic [2*DIM_W-1:0] p_s;
  logic [2*DIM_W-1:0] widx_s;
  logic [31:0]        widx32_s;

  assign c_s      = mirror_i ? (width_i - col_i - DIM_W'(1)) : col_i;
  assign p_s      = ({{DIM_W{1'b0}}, row_i} * {{DIM_W{1'b0}}, width_i})
                  + {{DIM_W{1'b0}}, c_s};
  // PPW is a power of two, so the divide is a plain shift
  assign widx_s   = p_s >> SH;
  assign widx32_s = 32'(widx_s);
  assign addr_o   = base_i + (widx32_s << 2);

  if (PPW > 1) begin : g_lane
    assign lane_o = p_s[LANE_W-1:0];
  end else begin : g_nolane
    assign lane_o = 1'b0;
  end

endmodule

// File: rtl/pixel_blitter.sv
// Pixel blitter: pops a four-word command (sync, size, base, flags) from a
// first-word-fall-through FIFO, reads the source rectangle over AHB-Lite one
// word at a time, and pushes {transparent, pixel} entries into a pixel FIFO
// in row-major order (optionally mirrored horizontally).
//   clk, rst        : clock, synchronous active-high reset
//   rdata/rempty/rinc : command FIFO head, empty flag, pop strobe
//   wfull/winc/wdata  : pixel FIFO full flag, push strobe, push data
//   HADDR/HTRANS/HWRITE/HREADY/HRDATA : AHB-Lite read-only master
//   busy            : a frame is being processed
//   frame_done      : one-cycle pulse after the final pixel push
//   sync_err        : saturating count of discarded non-sync words
module pixel_blitter
  import blitter_pkg::*;
#(
  parameter  int PIX_W  = 16,
  parameter  int DIM_W  = 16,
  localparam int PPW    = 32 / PIX_W,
  localparam int LANE_W = (PPW > 1) ? $clog2(PPW) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      rdata,
  input  logic             rempty,
  output logic             rinc,
  input  logic             wfull,
  output logic             winc,
  output logic [PIX_W:0]   wdata,
  output logic [31:0]      HADDR,
  output logic [1:0]       HTRANS,
  output logic             HWRITE,
  input  logic             HREADY,
  input  logic [31:0]      HRDATA,
  output logic             busy,
  output logic             frame_done,
  output logic [7:0]       sync_err
);

  state_e              state_q, state_d;
  logic [DIM_W-1:0]    width_q, width_d, height_q, height_d;
  logic [DIM_W-1:0]    row_q, row_d, col_q, col_d;
  logic [31:0]         base_q, base_d;
  logic                trans_en_q, trans_en_d, mirror_q, mirror_d;
  logic [PIX_W-1:0]    key_q, key_d;
  logic [LANE_W-1:0]   lane_q, lane_d;
  logic [31:0]         buf_q, buf_d, buf_addr_q, buf_addr_d;
  logic                buf_valid_q, buf_valid_d;
  logic [31:0]         haddr_q, haddr_d;
  logic [1:0]          htrans_q, htrans_d;
  logic [PIX_W:0]      wdata_q, wdata_d;
  logic                frame_done_q, frame_done_d;
  logic [7:0]          sync_err_q, sync_err_d;

  logic                pop_s, push_s, last_col_s, last_pix_s;
  logic [DIM_W-1:0]    gen_row_s, gen_col_s;
  logic                gen_mirror_s;
  logic [31:0]         gen_addr_s;
  logic [LANE_W-1:0]   gen_lane_s;

  // Select a lane from a word and tag it when it matches the colour key
  function automatic logic [PIX_W:0] make_px(input logic [31:0]       w,
                                             input logic [LANE_W-1:0] l,
                                             input logic              en,
                                             input logic [PIX_W-1:0]  k);
    logic [PIX_W-1:0] px;
    px = PIX_W'(w >> (PIX_W * int'(l)));
    return {(en && (px == k)), px};
  endfunction

  // Pops are gated by rst so a reset never consumes a command word
  assign pop_s  = !rst && !rempty &&
                  ((state_q == S_IDLE) || (state_q == S_SIZE) ||
                   (state_q == S_BASE) || (state_q == S_FLAGS));
  assign push_s = !rst && (state_q == S_EMIT) && !wfull;

  assign last_col_s = (col_q == (width_q - DIM_W'(1)));
  assign last_pix_s = last_col_s && (row_q == (height_q - DIM_W'(1)));

  assign rinc       = pop_s;
  assign winc       = push_s;
  assign wdata      = wdata_q;
  assign HADDR      = haddr_q;
  assign HTRANS     = htrans_q;
  assign HWRITE     = 1'b0;
  assign busy       = (state_q != S_IDLE);
  assign frame_done = frame_done_q;
  assign sync_err   = sync_err_q;

  // Position of the pixel that will be needed next, fed to the address generator
  always_comb begin
    gen_row_s    = row_q;
    gen_col_s    = col_q;
    gen_mirror_s = mirror_q;
    case (state_q)
      S_FLAGS: begin
        // mirror comes straight from the flags word being popped
        gen_row_s    = {DIM_W{1'b0}};
        gen_col_s    = {DIM_W{1'b0}};
        gen_mirror_s = rdata[FLAG_MIRROR_BIT];
      end
      S_EMIT: begin
        if (last_col_s) begin
          gen_row_s = row_q + DIM_W'(1);
          gen_col_s = {DIM_W{1'b0}};
        end else begin
          gen_row_s = row_q;
          gen_col_s = col_q + DIM_W'(1);
        end
      end
      default: begin
        gen_row_s = row_q;
        gen_col_s = col_q;
      end
    endcase
  end

  blit_addr_gen #(
    .PIX_W (PIX_W),
    .DIM_W (DIM_W)
  ) u_addr_gen (
    .row_i    (gen_row_s),
    .col_i    (gen_col_s),
    .width_i  (width_q),
    .base_i   (base_q),
    .mirror_i (gen_mirror_s),
    .addr_o   (gen_addr_s),
    .lane_o   (gen_lane_s)
  );

  // Next-state and datapath update logic
  always_comb begin
    state_d      = state_q;
    width_d      = width_q;
    height_d     = height_q;
    row_d        = row_q;
    col_d        = col_q;
    base_d       = base_q;
    trans_en_d   = trans_en_q;
    mirror_d     = mirror_q;
    key_d        = key_q;
    lane_d       = lane_q;
    buf_d        = buf_q;
    buf_addr_d   = buf_addr_q;
    buf_valid_d  = buf_valid_q;
    haddr_d      = haddr_q;
    wdata_d      = wdata_q;
    sync_err_d   = sync_err_q;
    frame_done_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (pop_s && (rdata == SYNC_WORD)) begin
          state_d = S_SIZE;
        end else if (pop_s) begin
          sync_err_d = sat_inc8(sync_err_q);
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SIZE: begin
        if (pop_s) begin
          width_d  = rdata[DIM_W-1:0];
          height_d = rdata[16 +: DIM_W];
          state_d  = S_BASE;
        end else begin
          state_d = S_SIZE;
        end
      end
      S_BASE: begin
        if (pop_s) begin
          base_d  = {rdata[31:2], 2'b00};
          state_d = S_FLAGS;
        end else begin
          state_d = S_BASE;
        end
      end
      S_FLAGS: begin
        if (pop_s) begin
          trans_en_d = rdata[FLAG_TRANS_BIT];
          mirror_d   = rdata[FLAG_MIRROR_BIT];
          key_d      = PIX_W'(rdata >> FLAG_KEY_LSB);
          row_d      = {DIM_W{1'b0}};
          col_d      = {DIM_W{1'b0}};
          if ((width_q == {DIM_W{1'b0}}) || (height_q == {DIM_W{1'b0}})) begin
            state_d      = S_IDLE;
            frame_done_d = 1'b1;
          end else begin
            // buffer is always invalid at frame start, so fetch
            haddr_d = gen_addr_s;
            lane_d  = gen_lane_s;
            state_d = S_ADDR;
          end
        end else begin
          state_d = S_FLAGS;
        end
      end
      S_ADDR: begin
        state_d = S_DATA;
      end
      S_DATA: begin
        if (HREADY) begin
          buf_d       = HRDATA;
          buf_addr_d  = haddr_q;
          buf_valid_d = 1'b1;
          wdata_d     = make_px(HRDATA, lane_q, trans_en_q, key_q);
          state_d     = S_EMIT;
        end else begin
          state_d = S_DATA;
        end
      end
      S_EMIT: begin
        if (push_s && last_pix_s) begin
          state_d      = S_IDLE;
          frame_done_d = 1'b1;
          buf_valid_d  = 1'b0;
        end else if (push_s) begin
          row_d  = gen_row_s;
          col_d  = gen_col_s;
          lane_d = gen_lane_s;
          if (buf_valid_q && (gen_addr_s == buf_addr_q)) begin
            wdata_d = make_px(buf_q, gen_lane_s, trans_en_q, key_q);
            state_d = S_EMIT;
          end else begin
            haddr_d = gen_addr_s;
            state_d = S_ADDR;
          end
        end else begin
          state_d = S_EMIT;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    // NONSEQ lasts exactly the one S_ADDR cycle
    htrans_d = (state_d == S_ADDR) ? HTRANS_NONSEQ : HTRANS_IDLE;
  end

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      width_q      <= {DIM_W{1'b0}};
      height_q     <= {DIM_W{1'b0}};
      row_q        <= {DIM_W{1'b0}};
      col_q        <= {DIM_W{1'b0}};
      base_q       <= 32'h0;
      trans_en_q   <= 1'b0;
      mirror_q     <= 1'b0;
      key_q        <= {PIX_W{1'b0}};
      lane_q       <= {LANE_W{1'b0}};
      buf_q        <= 32'h0;
      buf_addr_q   <= 32'h0;
      buf_valid_q  <= 1'b0;
      haddr_q      <= 32'h0;
      htrans_q     <= HTRANS_IDLE;
      wdata_q      <= {(PIX_W+1){1'b0}};
      frame_done_q <= 1'b0;
      sync_err_q   <= 8'h00;
    end else begin
      state_q      <= state_d;
      width_q      <= width_d;
      height_q     <= height_d;
      row_q        <= row_d;
      col_q        <= col_d;
      base_q       <= base_d;
      trans_en_q   <= trans_en_d;
      mirror_q     <= mirror_d;
      key_q        <= key_d;
      lane_q       <= lane_d;
      buf_q        <= buf_d;
      buf_addr_q   <= buf_addr_d;
      buf_valid_q  <= buf_valid_d;
      haddr_q      <= haddr_d;
      htrans_q     <= htrans_d;
      wdata_q      <= wdata_d;
      frame_done_q <= frame_done_d;
      sync_err_q   <= sync_err_d;
    end
  end

endmodule

// File: tb/tb_pixel_blitter.sv
// Testbench for pixel_blitter: command FIFO and AHB slave models driven on the
// falling edge, a table of frame vectors, a pixel/address scoreboard filled
// from a reference traversal, plus a mid-frame reset sequence.
module tb_pixel_blitter;
  import blitter_pkg::*;

  localparam int PIX_W = 16;
  localparam int DIM_W = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] rdata = 32'h0;
  logic        rempty = 1'b1;
  logic        rinc;
  logic        wfull = 1'b0;
  logic        winc;
  logic [16:0] wdata;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic        HREADY = 1'b1;
  logic [31:0] HRDATA = 32'h0;
  logic        busy;
  logic        frame_done;
  logic [7:0]  sync_err;

  always #5 clk = ~clk;

  pixel_blitter #(.PIX_W(PIX_W), .DIM_W(DIM_W)) dut (
    .clk(clk), .rst(rst), .rdata(rdata), .rempty(rempty), .rinc(rinc),
    .wfull(wfull), .winc(winc), .wdata(wdata), .HADDR(HADDR), .HTRANS(HTRANS),
    .HWRITE(HWRITE), .HREADY(HREADY), .HRDATA(HRDATA), .busy(busy),
    .frame_done(frame_done), .sync_err(sync_err)
  );

  typedef struct {
    int          n_garbage;
    logic [31:0] w1, w2, w3;
    int          waits;
    bit          tog;
    int          exp_push, exp_fetch, exp_transp;
    logic [7:0]  exp_serr;
    logic [15:0] exp_first;
  } vec_t;

  int checks = 0, errors = 0;

  logic [31:0] cmd_q[$];
  logic [16:0] exp_pix_q[$];
  logic [31:0] exp_addr_q[$];

  bit          pop_pend = 1'b0, dp = 1'b0, given_now = 1'b0;
  bit          chk_w3 = 1'b0, chk_data = 1'b0, frame_nonempty = 1'b0, tog_cfg = 1'b0;
  int          dp_wait = 0, waits_cfg = 0;
  logic [31:0] dp_addr = 32'h0, tmp_w;
  int          push_cnt = 0, fetch_cnt = 0, transp_cnt = 0, fd_cnt = 0;
  logic [15:0] first_pix = 16'h0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Memory word n holds {n6n1, n6n1}
  function automatic logic [31:0] mem_word(input logic [31:0] n);
    logic [15:0] h;
    h = 16'h0601 + (n[15:0] * 16'h1010);
    return {h, h};
  endfunction

  // Environment: FIFO/slave drive on the falling edge, then sample 1ns later
  always @(negedge clk) begin
    if (pop_pend) begin
      tmp_w    = cmd_q.pop_front();
      pop_pend = 1'b0;
    end
    rempty = (cmd_q.size() == 0);
    rdata  = rempty ? 32'h0 : cmd_q[0];
    wfull  = tog_cfg ? ~wfull : 1'b0;
    given_now = 1'b0;
    if (HTRANS == HTRANS_NONSEQ) begin
      check("one_outstanding", {31'h0, dp}, 32'h0);
      if (exp_addr_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_fetch actual=%h required=none", HADDR);
      end else begin
        check("haddr", HADDR, exp_addr_q.pop_front());
      end
      fetch_cnt++;
      dp = 1'b1; dp_wait = waits_cfg; dp_addr = HADDR; HREADY = 1'b1;
    end else if (dp && (dp_wait > 0)) begin
      HREADY = 1'b0; dp_wait--;
    end else if (dp) begin
      HREADY = 1'b1; HRDATA = mem_word(dp_addr >> 2); dp = 1'b0; given_now = 1'b1;
    end else begin
      HREADY = 1'b1;
    end
    #1;
    if (chk_w3) begin
      chk_w3 = 1'b0;
      if (frame_nonempty) check("w3_to_nonseq", {30'h0, HTRANS}, {30'h0, HTRANS_NONSEQ});
      else                check("w3_to_done", {31'h0, frame_done}, 32'h1);
    end
    if (chk_data) check("data_to_winc", {31'h0, winc}, {31'h0, !wfull});
    chk_data = given_now;
    if (winc) begin
      check("winc_vs_wfull", {31'h0, wfull}, 32'h0);
      if (exp_pix_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_push actual=%h required=none", wdata);
      end else begin
        check("pixel", {15'h0, wdata}, {15'h0, exp_pix_q.pop_front()});
      end
      push_cnt++;
      if (wdata[16]) transp_cnt++;
      if (push_cnt == 1) first_pix = wdata[15:0];
    end
    if (frame_done) fd_cnt++;
    if (rinc && !rempty) begin
      pop_pend = 1'b1;
      if (cmd_q.size() == 1) chk_w3 = 1'b1;
    end
  end

  // Build reference traversal and queue the command words
  task automatic queue_frame(input vec_t v);
    int w, h, c, p;
    bit mir, ten, have_last;
    logic [15:0] key, pix;
    logic [31:0] a, last_a, word;
    w = int'(v.w1[15:0]); h = int'(v.w1[31:16]);
    mir = v.w3[1]; ten = v.w3[0]; key = v.w3[23:8];
    have_last = 1'b0; last_a = 32'h0;
    for (int r = 0; r < h; r++) begin
      for (int col = 0; col < w; col++) begin
        c = mir ? (w - 1 - col) : col;
        p = r * w + c;
        a = v.w2 + 32'(4 * (p / 2));
        word = mem_word(a >> 2);
        pix = (p % 2 == 1) ? word[31:16] : word[15:0];
        exp_pix_q.push_back({(ten && (pix == key)), pix});
        if (!have_last || (a != last_a)) exp_addr_q.push_back(a);
        have_last = 1'b1; last_a = a;
      end
    end
    waits_cfg = v.waits; tog_cfg = v.tog;
    push_cnt = 0; fetch_cnt = 0; transp_cnt = 0;
    frame_nonempty = (w != 0) && (h != 0);
    for (int g = 0; g < v.n_garbage; g++) cmd_q.push_back((g == 0) ? 32'h1234_5678 : 32'h0);
    cmd_q.push_back(SYNC_WORD);
    cmd_q.push_back(v.w1);
    cmd_q.push_back(v.w2);
    cmd_q.push_back(v.w3);
  endtask

  task automatic run_frame(input vec_t v, input string tag);
    int fd0, n;
    fd0 = fd_cnt;
    queue_frame(v);
    n = 0;
    while ((fd_cnt == fd0) && (n < 2000)) begin
      @(negedge clk); #2; n++;
    end
    if (fd_cnt == fd0) begin
      checks++; errors++;
      $display("FAIL %s_timeout actual=no_frame_done required=frame_done", tag);
    end
    check({tag, "_busy_low"}, {31'h0, busy}, 32'h0);
    repeat (3) @(negedge clk);
    #2;
    check({tag, "_done_pulses"}, fd_cnt - fd0, 32'h1);
    check({tag, "_pushes"}, push_cnt, v.exp_push);
    check({tag, "_fetches"}, fetch_cnt, v.exp_fetch);
    check({tag, "_transp"}, transp_cnt, v.exp_transp);
    check({tag, "_sync_err"}, {24'h0, sync_err}, {24'h0, v.exp_serr});
    check({tag, "_pix_left"}, exp_pix_q.size(), 32'h0);
    if (v.exp_push > 0) check({tag, "_first"}, {16'h0, first_pix}, {16'h0, v.exp_first});
    tog_cfg = 1'b0;
  endtask

  vec_t vecs[7];
  vec_t vr;

  initial begin
    int fd0, n;
    vecs[0] = '{n_garbage:0, w1:32'h0002_0004, w2:32'h0, w3:32'h0, waits:0, tog:1'b0,
                exp_push:8, exp_fetch:4, exp_transp:0, exp_serr:8'd0, exp_first:16'h0601};
    vecs[1] = '{n_garbage:0, w1:32'h0002_0004, w2:32'h0, w3:32'h2, waits:0, tog:1'b0,
                exp_push:8, exp_fetch:4, exp_transp:0, exp_serr:8'd0, exp_first:16'h1611};
    vecs[2] = '{n_garbage:0, w1:32'h0002_0004, w2:32'h0, w3:32'h0016_1101, waits:0, tog:1'b0,
                exp_push:8, exp_fetch:4, exp_transp:2, exp_serr:8'd0, exp_first:16'h0601};
    vecs[3] = '{n_garbage:0, w1:32'h0002_0004, w2:32'h0, w3:32'h0, waits:3, tog:1'b1,
                exp_push:8, exp_fetch:4, exp_transp:0, exp_serr:8'd0, exp_first:16'h0601};
    vecs[4] = '{n_garbage:2, w1:32'h0002_0004, w2:32'h0, w3:32'h0, waits:0, tog:1'b0,
                exp_push:8, exp_fetch:4, exp_transp:0, exp_serr:8'd2, exp_first:16'h0601};
    vecs[5] = '{n_garbage:0, w1:32'h0000_0005, w2:32'h0, w3:32'h0, waits:0, tog:1'b0,
                exp_push:0, exp_fetch:0, exp_transp:0, exp_serr:8'd2, exp_first:16'h0};
    vecs[6] = '{n_garbage:0, w1:32'h0002_0003, w2:32'h40, w3:32'h2, waits:1, tog:1'b0,
                exp_push:6, exp_fetch:4, exp_transp:0, exp_serr:8'd2, exp_first:16'h1711};

    repeat (3) @(negedge clk);
    #2;
    check("rst_busy", {31'h0, busy}, 32'h0);
    check("rst_frame_done", {31'h0, frame_done}, 32'h0);
    check("rst_htrans", {30'h0, HTRANS}, 32'h0);
    check("rst_haddr", HADDR, 32'h0);
    check("rst_wdata", {15'h0, wdata}, 32'h0);
    check("rst_sync_err", {24'h0, sync_err}, 32'h0);
    check("rst_hwrite", {31'h0, HWRITE}, 32'h0);
    rst = 1'b0;

    for (int i = 0; i < 7; i++) begin
      run_frame(vecs[i], $sformatf("vec%0d", i));
    end

    // Reset while the second word's data phase is stalled
    vr = vecs[0];
    vr.waits = 3;
    fd0 = fd_cnt;
    queue_frame(vr);
    n = 0;
    while (!(dp && (dp_addr == 32'h4)) && (n < 500)) begin
      @(negedge clk); #2; n++;
    end
    if (!(dp && (dp_addr == 32'h4))) begin
      checks++; errors++;
      $display("FAIL rst_mid_timeout actual=no_fetch required=fetch_4");
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    #2;
    check("mid_rinc", {31'h0, rinc}, 32'h0);
    check("mid_winc", {31'h0, winc}, 32'h0);
    check("mid_busy", {31'h0, busy}, 32'h0);
    check("mid_frame_done", {31'h0, frame_done}, 32'h0);
    check("mid_htrans", {30'h0, HTRANS}, 32'h0);
    check("mid_haddr", HADDR, 32'h0);
    check("mid_wdata", {15'h0, wdata}, 32'h0);
    check("mid_sync_err", {24'h0, sync_err}, 32'h0);
    check("mid_pushes_before", push_cnt, 32'h2);
    rst = 1'b0;
    exp_pix_q.delete();
    exp_addr_q.delete();
    dp = 1'b0; chk_data = 1'b0; chk_w3 = 1'b0; pop_pend = 1'b0;
    repeat (4) @(negedge clk);
    #2;
    check("mid_no_done", fd_cnt - fd0, 32'h0);
    check("mid_idle_busy", {31'h0, busy}, 32'h0);

    run_frame(vecs[0], "post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pixel_blitter.md
PIXEL_BLITTER -- requirements
Module: pixel_blitter

Interface
REQ-001 Parameters SHALL be: PIX_W, default 16, pixel width (8, 16 or 32); DIM_W, default 16, width/height field width (at most 16); PPW = 32/PIX_W, derived pixels per AHB word.
REQ-002 clk  in  1  sole clock, all logic on its rising edge.
REQ-003 rst  in  1  synchronous, active-high reset.
REQ-004 rdata  in  32  command FIFO head word; first-word-fall-through.
REQ-005 rempty  in  1  command FIFO empty.
REQ-006 rinc  out  1  command pop; rdata is consumed on a cycle where rinc=1 and rempty=0.
REQ-007 wfull  in  1  pixel FIFO full.
REQ-008 winc  out  1  pixel push.
REQ-009 wdata  out  PIX_W+1  {transparent flag, pixel}.
REQ-010 HADDR  out  32  AHB-Lite byte address.
REQ-011 HTRANS  out  2  IDLE=00 or NONSEQ=10 only.
REQ-012 HWRITE  out  1  tied 0 (read-only master).
REQ-013 HREADY  in  1  AHB ready.
REQ-014 HRDATA  in  32  AHB read data.
REQ-015 busy  out  1  high from the first header-word pop until the frame completes.
REQ-016 frame_done  out  1  one-cycle pulse after the last pixel push.
REQ-017 sync_err  out  8  saturating count of non-sync words discarded in IDLE.

Function
REQ-018 The command SHALL be four words: W0 sync = 32'hFFFF_FFFF; W1 = {height[31:16], width[15:0]}; W2 = source base byte address, word aligned; W3 = {key[31:0]..}: bit0 transparency enable, bit1 horizontal mirror, bits[PIX_W+7:8] key colour.
REQ-019 The state machine SHALL have the states S_IDLE -> S_SIZE -> S_BASE -> S_FLAGS -> S_ADDR -> S_DATA -> S_EMIT (returning to S_ADDR or S_EMIT) -> S_IDLE.
REQ-020 rinc SHALL be asserted only in S_IDLE, S_SIZE, S_BASE and S_FLAGS, and only when rempty=0; these states advance only on a pop.
REQ-021 In S_IDLE, a popped word that is not the sync word SHALL be discarded and sync_err incremented, saturating at 255.
REQ-022 Pixel traversal SHALL be row-major; the source index is p = row*width + c, where c = col, or c = width-1-col when mirror is set.
REQ-023 The word address SHALL be HADDR = base + 4*(p/PPW); the lane SHALL be p%PPW; lane 0 is HRDATA[PIX_W-1:0].
REQ-024 A fetch SHALL occur only when the needed word address differs from the buffered word address, or the buffer is invalid; otherwise the FSM goes directly to S_EMIT.
REQ-025 In S_ADDR, HTRANS=NONSEQ and HADDR SHALL be driven for exactly one cycle, then S_DATA is entered with HTRANS=IDLE.
REQ-026 In S_DATA, the FSM SHALL hold while HREADY=0; on HREADY=1 it latches HRDATA into the buffer and enters S_EMIT.
REQ-027 In S_EMIT, winc SHALL be asserted iff wfull=0; a stall holds wdata and all counters.
REQ-028 wdata[PIX_W] SHALL be 1 iff transparency is enabled and the pixel equals key; transparent pixels are still pushed, so position is preserved.
REQ-029 After the push of pixel (height-1, width-1), frame_done SHALL pulse the next cycle, busy falls, and the buffer is invalidated.
REQ-030 width=0 or height=0 SHALL complete with no AHB transfer and no push, and frame_done SHALL pulse one cycle after the W3 pop.
REQ-031 Latency SHALL be: W3 pop -> NONSEQ the next cycle; HREADY=1 data phase -> first winc the next cycle.
REQ-032 Row and column counters SHALL be DIM_W bits wide; p SHALL be 2*DIM_W bits wide; address arithmetic is 32-bit modulo 2^32 (wrap allowed).
REQ-033 Only one AHB transfer SHALL be outstanding at a time; the block never issues NONSEQ while in S_DATA.

Reset
REQ-034 While rst=1 at a clock edge, the next state SHALL be: state S_IDLE; rinc, winc, busy, frame_done = 0; HTRANS=IDLE; HADDR=0; wdata=0; sync_err=0; buffer invalid.
REQ-035 Reset mid-frame SHALL abandon the frame and any AHB data phase without a frame_done pulse, and SHALL NOT cause additional FIFO pops.

Structure
REQ-036 The package blitter_pkg SHALL hold: the state enum, HTRANS_IDLE/HTRANS_NONSEQ, the SYNC_WORD constant, and the W3 flag bit positions.
REQ-037 The sub-module blit_addr_gen SHALL compute the word address and lane from row, col, width, base and mirror (combinational, parametrised by PIX_W/DIM_W).

Verification
REQ-038 FIFO words FFFF_FFFF, 0002_0004, 0, 0, with memory word n = {n6n1, n6n1} hex and no wait states -> 8 pushes: 0601,0601,1611,1611,2621,2621,3631,3631; HADDR sequence 0,4,8,C; one frame_done.
REQ-039 Same frame with mirror=1 -> row 0 order 1611,1611,0601,0601; row 1 order 3631,3631,2621,2621.
REQ-040 W3 = 0x0016_1101 (transparency on, key 1611) -> pushes of 1611 carry wdata[16]=1; all others carry 0.
REQ-041 HREADY low for 3 cycles per transfer and wfull toggling every other cycle -> identical pixel sequence; no push while wfull=1; HTRANS is NONSEQ once per word.
REQ-042 Leading words 1234_5678, 0 before sync -> sync_err=2 and the frame decodes correctly; a size word of 0000_0005 -> no AHB transfer and frame_done one cycle after the W3 pop.
REQ-043 rst asserted during S_DATA of word 2 -> all outputs at reset values the next cycle; a following full command runs correctly from S_IDLE.
